// File: rtl/jk_pkg.sv
// Shared types for the JK flip-flop checker: FSM states, J/K codes and the
// next-state rule of an ideal JK flip-flop.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2
    } jk_state_t;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] CLR  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    function automatic logic jk_next(input logic cur_q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            HOLD:    nq = cur_q;
            CLR:     nq = 1'b0;
            SET:     nq = 1'b1;
            default: nq = ~cur_q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Registered reference JK flip-flop. 'load' replaces the current state with
// load_val before the J/K rule is applied, so a resync and an update can share an edge.
module jk_ref_model
    import jk_pkg::*;
(
    input  logic clk,
    input  logic load,
    input  logic load_val,
    input  logic upd,
    input  logic j,
    input  logic k,
    output logic model_q
);

    logic base_q;

    assign base_q = load ? load_val : model_q;

    always_ff @(posedge clk) begin
        if (upd) begin
            model_q <= jk_next(base_q, j, k);
        end else if (load) begin
            model_q <= load_val;
        end
    end

endmodule

// File: rtl/jk_ff_checker.sv
// Online checker for an external JK flip-flop: tracks it with a reference
// model, flags q / qbar faults and keeps error and check counters.
// Define JK_CHK_QBAR_EN to enable the qbar complement check.
module jk_ff_checker
    import jk_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int CHK_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             qbar,
    output logic             q_err,
    output logic             qbar_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CHK_W-1:0] chk_cnt,
    output logic             busy
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
        return (val == ERR_MAX) ? val : val + 1'b1;
    endfunction

    jk_state_t state;
    jk_state_t state_nxt;
    logic      do_sync;
    logic      do_check;
    logic      model_q;
    logic      q_mis;
    logic      qbar_mis;
    logic      any_err;
    logic      ref_load;
    logic      ref_load_val;
    logic      ref_upd;

    always_comb begin
        state_nxt = state;
        do_sync   = 1'b0;
        do_check  = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = SYNC;
            end
            SYNC: begin
                if (en) begin
                    state_nxt = CHECK;
                    do_sync   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CHECK: begin
                if (en) do_check  = 1'b1;
                else    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign q_mis = (q != model_q);

`ifdef JK_CHK_QBAR_EN
    assign qbar_mis = (qbar == q);
`else
    logic unused_qbar;
    assign unused_qbar = qbar;
    assign qbar_mis    = 1'b0;
`endif

    assign any_err = do_check & (q_mis | qbar_mis);

    // The observed flop has no reset, so the model is seeded from q in SYNC and
    // reseeded after any q mismatch; one fault then yields exactly one error.
    assign ref_load     = rst | do_sync | (do_check & q_mis);
    assign ref_load_val = rst ? 1'b0 : q;
    assign ref_upd      = ~rst & (do_sync | do_check);

    jk_ref_model u_ref (
        .clk      (clk),
        .load     (ref_load),
        .load_val (ref_load_val),
        .upd      (ref_upd),
        .j        (j),
        .k        (k),
        .model_q  (model_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q_err      <= 1'b0;
            qbar_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            chk_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            q_err    <= do_check & q_mis;
            qbar_err <= do_check & qbar_mis;
            if (do_check) chk_cnt <= chk_cnt + 1'b1;
            if (any_err) begin
                err_cnt    <= sat_inc(err_cnt);
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_ff_checker.sv
// Randomized + directed bench for jk_ff_checker against a cycle-level
// behavioural model; honours JK_CHK_QBAR_EN like the design.
module tb_jk_ff_checker;

    localparam int ERR_W   = 4;
    localparam int CHK_W   = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef JK_CHK_QBAR_EN
    localparam bit QB = 1'b1;
`else
    localparam bit QB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic j = 1'b0;
    logic k = 1'b0;
    logic q = 1'b1;
    logic qbar;
    logic fault = 1'b0;
    logic qbar_eq = 1'b0;

    logic             q_err;
    logic             qbar_err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;
    logic [CHK_W-1:0] chk_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int qerr_pulses = 0;

    jk_ff_checker #(.ERR_W(ERR_W), .CHK_W(CHK_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .j          (j),
        .k          (k),
        .q          (q),
        .qbar       (qbar),
        .q_err      (q_err),
        .qbar_err   (qbar_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .chk_cnt    (chk_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic jkf(input logic qq, input logic jj, input logic kk);
        return (jj & ~qq) | (~kk & qq);
    endfunction

    // Observed flip-flop; 'fault' makes it land on the wrong value for one edge.
    always @(posedge clk) q <= fault ? ~jkf(q, j, k) : jkf(q, j, k);
    assign qbar = qbar_eq ? q : ~q;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: run = consecutive enabled edges since idle
    // (0: going to SYNC, 1: SYNC edge, >=2: check edge).
    bit m_valid = 1'b0;
    int m_run = 0;
    bit m_pq, m_pj, m_pk;
    bit m_qerr, m_qbarerr, m_sticky, m_busy;
    int m_err = 0;
    int m_chk = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1;
            m_run = 0; m_qerr = 0; m_qbarerr = 0; m_sticky = 0; m_busy = 0;
            m_err = 0; m_chk = 0;
        end else if (!en) begin
            m_run = 0; m_qerr = 0; m_qbarerr = 0; m_busy = 0;
        end else begin
            if (m_run >= 2) begin
                m_qerr    = (q != jkf(m_pq, m_pj, m_pk));
                m_qbarerr = QB && (qbar == q);
                m_chk     = (m_chk + 1) % (1 << CHK_W);
                if (m_qerr || m_qbarerr) begin
                    m_err    = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                    m_sticky = 1'b1;
                end
            end else begin
                m_qerr = 0; m_qbarerr = 0;
            end
            m_run  = (m_run < 2) ? m_run + 1 : 2;
            m_busy = 1'b1;
            m_pq = q; m_pj = j; m_pk = k;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (q_err) qerr_pulses++;
            chk("q_err", q_err, m_qerr);
            chk("qbar_err", qbar_err, m_qbarerr);
            chk("err_sticky", err_sticky, m_sticky);
            chk("err_cnt", err_cnt, m_err);
            chk("chk_cnt", chk_cnt, m_chk);
            chk("busy", busy, m_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int c0, p0;

    initial begin
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_chk_cnt", chk_cnt, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_q_err", q_err, 0);
        rst = 1'b0;
        tick();

        // Clean run: one SYNC then 19 checks over 10,01,00,11 x5
        en = 1'b1; j = 0; k = 0;
        tick();
        p0 = qerr_pulses;
        for (int i = 0; i < 20; i++) begin
            j = (i < 5) || (i >= 15);
            k = (i >= 5 && i < 10) || (i >= 15);
            tick();
        end
        chk("clean_chk_cnt", chk_cnt, 19);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_pulses", qerr_pulses - p0, 0);

        // Flop fails to set once: exactly one q_err, one cycle after the set edge
        j = 0; k = 1; tick();
        p0 = qerr_pulses;
        j = 1; k = 0; fault = 1'b1; tick();
        chk("stuck_q_err_t", q_err, 0);
        fault = 1'b0; j = 0; k = 0; tick();
        chk("stuck_q_err_t1", q_err, 1);
        chk("stuck_err_cnt", err_cnt, 1);
        tick();
        chk("stuck_q_err_t2", q_err, 0);
        tick(); tick();
        chk("stuck_pulses", qerr_pulses - p0, 1);
        chk("stuck_sticky", err_sticky, 1);

        // qbar equal to q for three checks
        qbar_eq = 1'b1;
        repeat (3) tick();
        qbar_eq = 1'b0;
        tick(); tick();
        chk("qbar_err_cnt", err_cnt, QB ? 4 : 1);

        // en low for three cycles, then resync
        c0 = chk_cnt;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_busy", busy, 0);
            chk("pause_chk_cnt", chk_cnt, c0);
        end
        chk("pause_sticky", err_sticky, 1);
        en = 1'b1;
        tick();
        chk("resync_busy", busy, 1);
        chk("resync_chk0", chk_cnt, c0);
        tick();
        chk("resync_chk1", chk_cnt, c0);
        tick();
        chk("resync_chk2", chk_cnt, c0 + 1);

        // Reset in the middle of checking
        rst = 1'b1; tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_err_cnt", err_cnt, 0);
        chk("mrst_chk_cnt", chk_cnt, 0);
        chk("mrst_sticky", err_sticky, 0);
        chk("mrst_q_err", q_err, 0);
        chk("mrst_qbar_err", qbar_err, 0);
        rst = 1'b0;

        // Error every check for 20 cycles saturates the 4-bit counter
        tick(); tick();
        fault = 1'b1;
        repeat (20) begin
            j = 1'($urandom); k = 1'($urandom);
            tick();
        end
        fault = 1'b0;
        tick();
        chk("sat_err_cnt", err_cnt, 15);
        chk("sat_sticky", err_sticky, 1);

        // Random traffic
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(15) != 0);
            j       = 1'($urandom);
            k       = 1'($urandom);
            fault   = ($urandom_range(19) == 0);
            qbar_eq = ($urandom_range(19) == 0);
            rst     = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0; fault = 1'b0; qbar_eq = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
